// File: rtl/dap_pkt_fifo_if.sv
// dap_pkt_fifo_if - byte-stream and status bundle for dap_pkt_fifo.
//   s_tvalid/s_tready/s_tdata : inbound bytes from the WinUSB bulk OUT stream
//   m_tvalid/m_tready/m_tdata/m_tlast : packetised bytes toward DAP_Controller
//   level, pkt_cnt, pkt_irq   : occupancy and packet status for firmware
// Modport slave is the FIFO's view; modport master is the view of the logic
// around it (stream source, downstream consumer and status reader).
interface dap_pkt_fifo_if #(
    parameter int ADDR_W = 9
);
    logic              s_tvalid;
    logic              s_tready;
    logic [7:0]        s_tdata;
    logic              m_tvalid;
    logic              m_tready;
    logic [7:0]        m_tdata;
    logic              m_tlast;
    logic [ADDR_W:0]   level;
    logic [7:0]        pkt_cnt;
    logic              pkt_irq;

    modport slave (
        input  s_tvalid, s_tdata, m_tready,
        output s_tready, m_tvalid, m_tdata, m_tlast, level, pkt_cnt, pkt_irq
    );

    modport master (
        output s_tvalid, s_tdata, m_tready,
        input  s_tready, m_tvalid, m_tdata, m_tlast, level, pkt_cnt, pkt_irq
    );
endinterface

// File: rtl/dap_pkt_fifo.sv
// dap_pkt_fifo - packetising byte FIFO between the WinUSB bulk OUT stream and
// the DAP controller input, hclk domain.
// The incoming stream carries no packet boundaries; they are recovered here.
// A byte ends its packet when the input then stays idle for IDLE_CYCLES, or
// when it brings the packet length to MAX_PKT.
// Ports:
//   hclk    : clock, rising edge
//   hresetn : asynchronous active-low reset
//   bus     : dap_pkt_fifo_if.slave (input stream, output stream, status)
module dap_pkt_fifo #(
    parameter int ADDR_W      = 9,
    parameter int MAX_PKT     = 512,
    parameter int IDLE_CYCLES = 64
) (
    input  logic           hclk,
    input  logic           hresetn,
    dap_pkt_fifo_if.slave  bus
);
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int PW     = ADDR_W + 1;
    localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);

    logic [8:0]        r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW-1:0]     r_pkt_true;
    logic              r_run;
    logic              r_pend_v;
    logic [7:0]        r_pend_d;
    logic              r_tmo_wait;
    logic [IDLE_W-1:0] r_idle_cnt;
    logic [15:0]       r_len_cnt;
    logic [7:0]        r_out_data;
    logic              r_out_last;

    logic              w_empty;
    logic              w_full;
    logic              w_rd_fire;
    logic              w_idle_hit;
    logic              w_s_tready;
    logic              w_in_fire;
    logic              w_len_max;
    logic              w_tmo_commit;
    logic              w_commit;
    logic              w_commit_last;
    logic [PW-1:0]     w_rd_next;
    logic              w_bypass;
    logic              w_out_load;
    logic              w_pkt_dec;
    logic [PW+7:0]     w_pkt_wide;

    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                        (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
    assign w_rd_fire  = !w_empty && bus.m_tready;

    // Once the idle count has reached its limit the pending byte is owned by
    // the timeout; input stays blocked until it has been committed.
    assign w_idle_hit = r_pend_v && (r_idle_cnt == IDLE_W'(IDLE_CYCLES));
    assign w_s_tready = r_run && !r_tmo_wait && !w_idle_hit &&
                        (!r_pend_v || !w_full || w_rd_fire);
    assign w_in_fire  = bus.s_tvalid && w_s_tready;

    assign w_len_max     = (r_len_cnt == 16'(MAX_PKT));
    assign w_tmo_commit  = r_tmo_wait && (!w_full || w_rd_fire);
    assign w_commit      = (w_in_fire && r_pend_v) || w_tmo_commit;
    // Input and timeout commits never coincide: tmo_wait blocks input.
    assign w_commit_last = w_tmo_commit || w_len_max;

    // The output register always holds the entry at the read pointer. When
    // the entry being committed lands exactly there, take it straight from
    // the pending byte instead of the (not yet written) memory.
    assign w_rd_next  = r_rd_ptr + PW'(w_rd_fire);
    assign w_bypass   = w_commit && (w_rd_next == r_wr_ptr);
    assign w_out_load = w_rd_fire || w_bypass;
    assign w_pkt_dec  = w_rd_fire && r_out_last;

    assign w_pkt_wide = {8'd0, r_pkt_true};

    assign bus.s_tready = w_s_tready;
    assign bus.m_tvalid = !w_empty;
    assign bus.m_tdata  = r_out_data;
    assign bus.m_tlast  = r_out_last;
    assign bus.level    = r_wr_ptr - r_rd_ptr;
    assign bus.pkt_cnt  = (w_pkt_wide > (PW+8)'(255)) ? 8'hFF : w_pkt_wide[7:0];
    assign bus.pkt_irq  = w_commit && w_commit_last;

    always_ff @(posedge hclk) begin
        if (w_commit) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= {w_commit_last, r_pend_d};
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_run      <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_pkt_true <= '0;
            r_pend_v   <= 1'b0;
            r_pend_d   <= 8'd0;
            r_tmo_wait <= 1'b0;
            r_idle_cnt <= '0;
            r_len_cnt  <= 16'd0;
            r_out_data <= 8'd0;
            r_out_last <= 1'b0;
        end else begin
            r_run <= 1'b1;

            if (w_commit) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_rd_fire) begin
                r_rd_ptr <= w_rd_next;
            end
            if (w_out_load) begin
                if (w_bypass) begin
                    {r_out_last, r_out_data} <= {w_commit_last, r_pend_d};
                end else begin
                    {r_out_last, r_out_data} <= r_mem[w_rd_next[ADDR_W-1:0]];
                end
            end

            if (w_in_fire) begin
                r_pend_v   <= 1'b1;
                r_pend_d   <= bus.s_tdata;
                r_idle_cnt <= '0;
                r_len_cnt  <= (r_pend_v && w_len_max) ? 16'd1 : r_len_cnt + 16'd1;
            end else if (w_tmo_commit) begin
                r_pend_v   <= 1'b0;
                r_tmo_wait <= 1'b0;
                r_idle_cnt <= '0;
                r_len_cnt  <= 16'd0;
            end else if (w_idle_hit) begin
                r_tmo_wait <= 1'b1;
            end else if (r_pend_v) begin
                r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
            end

            // A last entry entering and one leaving in the same cycle cancel.
            if (bus.pkt_irq && !w_pkt_dec) begin
                r_pkt_true <= r_pkt_true + PW'(1);
            end else if (!bus.pkt_irq && w_pkt_dec) begin
                r_pkt_true <= r_pkt_true - PW'(1);
            end
        end
    end
endmodule

// File: tb/tb_dap_pkt_fifo.sv
// tb_dap_pkt_fifo - directed phases plus a random stream for dap_pkt_fifo.
// The reference model is a queue of committed {last,data} entries plus the
// pending byte, its packet length and the cycles since the last accepted byte.
// A byte is last when the next accepted byte comes IDLE or more idle cycles
// later (or never), or when it is byte MAX_PKT of its packet.
module tb_dap_pkt_fifo;
    localparam int ADDR_W  = 9;
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int MAX_PKT = 512;
    localparam int IDLE    = 64;

    logic hclk    = 1'b0;
    logic hresetn = 1'b0;

    dap_pkt_fifo_if #(.ADDR_W(ADDR_W)) bus ();

    dap_pkt_fifo #(
        .ADDR_W      (ADDR_W),
        .MAX_PKT     (MAX_PKT),
        .IDLE_CYCLES (IDLE)
    ) dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .bus     (bus)
    );

    always #5 hclk = ~hclk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int irq_cnt = 0;
    int last_irq_cyc = 0;
    int last_hs_cyc  = 0;
    int rd_mode = 0;            // 0: m_tready low, 1: high, 2: random
    logic [8:0] last_rd_word = 9'd0;

    // reference model state
    logic [8:0] mq[$];
    int         m_nlast = 0;
    bit         m_pend  = 0;
    logic [7:0] m_pend_d = 8'd0;
    int         m_since = 0;
    int         m_len   = 0;
    bit         m_run   = 0;

    bit hs, rf, full_e, rdy_e, tcommit, irq_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // downstream ready driver
    initial begin
        bus.m_tready = 1'b0;
        forever begin
            @(posedge hclk);
            #1;
            case (rd_mode)
                1:       bus.m_tready = 1'b1;
                2:       bus.m_tready = ($urandom_range(0, 3) != 0);
                default: bus.m_tready = 1'b0;
            endcase
        end
    end

    // monitor: compares DUT against the model, then advances the model
    initial begin
        forever begin
            @(negedge hclk);
            cyc++;
            if (!hresetn) begin
                check("rst_s_tready", 32'(bus.s_tready), 0);
                check("rst_m_tvalid", 32'(bus.m_tvalid), 0);
                check("rst_m_tdata",  32'(bus.m_tdata),  0);
                check("rst_m_tlast",  32'(bus.m_tlast),  0);
                check("rst_level",    32'(bus.level),    0);
                check("rst_pkt_cnt",  32'(bus.pkt_cnt),  0);
                check("rst_pkt_irq",  32'(bus.pkt_irq),  0);
                mq.delete();
                m_nlast = 0;
                m_pend  = 0;
                m_since = 0;
                m_len   = 0;
                m_run   = 0;
            end else begin
                hs     = bus.s_tvalid && bus.s_tready;
                rf     = bus.m_tvalid && bus.m_tready;
                full_e = (mq.size() == DEPTH);
                rdy_e  = m_run && !(m_pend && m_since >= IDLE) && (!m_pend || !full_e || rf);
                check("s_tready", 32'(bus.s_tready), 32'(rdy_e));
                check("m_tvalid", 32'(bus.m_tvalid), 32'(mq.size() != 0));
                check("level",    32'(bus.level),    32'(mq.size()));
                check("pkt_cnt",  32'(bus.pkt_cnt),  32'((m_nlast > 255) ? 255 : m_nlast));
                if (rf && mq.size() != 0) begin
                    check("rd_word", 32'({bus.m_tlast, bus.m_tdata}), 32'(mq[0]));
                    last_rd_word = {bus.m_tlast, bus.m_tdata};
                    m_nlast -= int'(mq[0][8]);
                    void'(mq.pop_front());
                end

                tcommit = m_pend && (m_since >= IDLE + 1) && (!full_e || rf);
                irq_e   = 1'b0;
                if (hs && m_pend) begin
                    irq_e = (m_len == MAX_PKT);
                    mq.push_back({irq_e, m_pend_d});
                end else if (tcommit) begin
                    irq_e = 1'b1;
                    mq.push_back({1'b1, m_pend_d});
                end
                m_nlast += int'(irq_e);
                check("pkt_irq", 32'(bus.pkt_irq), 32'(irq_e));

                if (bus.pkt_irq) begin
                    irq_cnt++;
                    last_irq_cyc = cyc;
                end
                if (hs) begin
                    last_hs_cyc = cyc;
                    m_len    = (m_pend && m_len == MAX_PKT) ? 1 : m_len + 1;
                    m_pend   = 1;
                    m_pend_d = bus.s_tdata;
                    m_since  = 0;
                end else if (tcommit) begin
                    m_pend  = 0;
                    m_len   = 0;
                    m_since = 0;
                end else if (m_pend) begin
                    m_since++;
                end
                m_run = 1;
            end
        end
    end

    // offer one byte, wait (bounded) for acceptance, then idle for gap cycles
    task automatic send(input logic [7:0] d, input int gap);
        int waited = 0;
        bus.s_tvalid = 1'b1;
        bus.s_tdata  = d;
        do begin
            @(negedge hclk);
            waited++;
        end while (!bus.s_tready && waited < 5000);
        if (!bus.s_tready) check("send_accept", 32'(bus.s_tready), 1);
        @(posedge hclk);
        #1;
        bus.s_tvalid = 1'b0;
        repeat (gap) begin
            @(posedge hclk);
            #1;
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge hclk);
            #1;
        end
    endtask

    task automatic wait_empty(input string name, input int bound);
        int n = 0;
        while ((bus.m_tvalid || bus.level != 0) && n < bound) begin
            @(negedge hclk);
            n++;
        end
        check(name, 32'(bus.level), 0);
        @(posedge hclk);
        #1;
    endtask

    initial begin
        int base;
        int hs03;
        bus.s_tvalid = 1'b0;
        bus.s_tdata  = 8'd0;

        // 1: short packet closed by idle timeout
        idle_cycles(3);
        hresetn = 1'b1;
        rd_mode = 1;
        idle_cycles(2);
        base = irq_cnt;
        send(8'h01, 0);
        send(8'h02, 0);
        send(8'h03, 0);
        hs03 = last_hs_cyc;
        idle_cycles(IDLE + 10);
        check("t1_irq_count", 32'(irq_cnt - base), 1);
        // hs03 is the sample just before the accepting edge
        check("t1_irq_delay", 32'(last_irq_cyc - (hs03 + 1)), IDLE + 1);
        check("t1_last_word", 32'(last_rd_word), 32'h103);

        // 2: continuous stream split at MAX_PKT
        base = irq_cnt;
        for (int i = 1; i <= 1030; i++) send(8'(i), 0);
        idle_cycles(IDLE + 10);
        check("t2_irq_count", 32'(irq_cnt - base), 3);
        wait_empty("t2_drain", 200);

        // 3: fill with reads stalled, then timeout on a full FIFO
        rd_mode = 0;
        idle_cycles(2);
        for (int i = 0; i < 513; i++) send(8'(i + 7), 0);
        repeat (2) @(negedge hclk);
        check("t3_level_full", 32'(bus.level), 512);
        check("t3_s_tready",   32'(bus.s_tready), 0);
        repeat (IDLE + 5) @(negedge hclk);
        check("t3_level_hold", 32'(bus.level), 512);
        check("t3_blocked",    32'(bus.s_tready), 0);
        @(posedge hclk);
        #2;
        rd_mode = 1;
        @(posedge hclk);
        @(negedge hclk);
        check("t3_tmo_irq",   32'(bus.pkt_irq), 1);
        check("t3_tmo_level", 32'(bus.level), 512);
        #1;
        wait_empty("t3_drain", 2000);
        check("t3_last_word", 32'(last_rd_word), 32'h100 | 32'(8'(512 + 7)));

        // 4: reset in the middle of a packet
        rd_mode = 0;
        idle_cycles(2);
        for (int i = 0; i < 10; i++) send(8'(8'h40 + i), 0);
        hresetn = 1'b0;
        #1;
        check("t4_s_tready", 32'(bus.s_tready), 0);
        check("t4_m_tvalid", 32'(bus.m_tvalid), 0);
        check("t4_m_tdata",  32'(bus.m_tdata),  0);
        check("t4_m_tlast",  32'(bus.m_tlast),  0);
        check("t4_level",    32'(bus.level),    0);
        check("t4_pkt_cnt",  32'(bus.pkt_cnt),  0);
        check("t4_pkt_irq",  32'(bus.pkt_irq),  0);
        @(posedge hclk);
        #1;
        hresetn = 1'b1;
        repeat (2) @(negedge hclk);
        check("t4_level_after", 32'(bus.level), 0);
        check("t4_pkt_after",   32'(bus.pkt_cnt), 0);
        rd_mode = 1;
        idle_cycles(2);
        send(8'hAA, 0);
        idle_cycles(IDLE + 10);
        check("t4_aa_word", 32'(last_rd_word), 32'h1AA);

        // 5: random bytes, random gaps, random downstream stalls
        rd_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            int gap;
            gap = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 2 * IDLE) : $urandom_range(0, 3);
            send(8'($urandom), gap);
        end
        idle_cycles(IDLE + 10);
        rd_mode = 1;
        wait_empty("t5_drain", 2000);
        check("t5_model_empty", 32'(mq.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
